helper_data_gen: RTL
====================

# helper_data_gen

Enrollment-side helper-data generator for the PUF key pipeline. It consumes the PUF response Pr and the per-bit target distance vector H[0:127] produced by the HD transform, and emits helper vectors F[i] = Pr XOR M[i], where mask M[i] has exactly H[i] ones. Vectors stream out one per handshake to helper storage. The MAP decoder later recovers the key from these vectors, because HD(F[i], Pr) = H[i].

## Interface
- N, 128, helper vector / PUF response width
- IDXW, 7, index and distance width (log2 N)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- Pr  in  N  PUF response; captured on accepted start
- H  in  IDXW x N (array [0:127])  target distances; captured on accepted start
- seed  in  16  LFSR seed; captured on accepted start
- f_ready  in  1  downstream accepts the current beat
- f_valid  out  1  beat valid
- f_data  out  N  helper vector F[f_idx]
- f_idx  out  IDXW  index of the current beat
- f_last  out  1  high with the beat where f_idx = N-1
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- FSM states: IDLE, GEN, DONE.
- IDLE → GEN on start. The block captures Pr_q, H_q[], and lfsr_q. If seed = 0, lfsr_q = 16'h0001. A start in GEN or DONE is ignored.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. It shifts left one step per accepted beat, with feedback = b15^b13^b12^b10 into bit 0.
- Beat i uses:
  - rotation r = lfsr[6:0] after i steps (beat 0 uses the captured seed value);
  - thermometer T = (1<<H_q[i]) − 1, computed at N bits, so H = 0 gives T = 0;
  - M = rotl(T, r) over N bits;
  - F = Pr_q ^ M.
- popcount(M) = H_q[i] exactly for every H value from 0 to 127. r = 0 means no rotation.
- GEN → DONE when the beat with f_last is accepted. DONE → IDLE after one cycle, with done = 1 for that cycle.
- There is no abort. Only rst terminates a run.

## Timing
- Reset values: all outputs are 0 (f_valid, f_data, f_idx, f_last, busy, done). The FSM is in IDLE and lfsr_q = 0.
- Cycle 0: start is sampled. Cycle 1: busy = 1, f_valid = 1, f_idx = 0, with f_data registered.
- All outputs come from registers. No combinational path runs from f_ready to any output.
- While f_valid & !f_ready, f_data, f_idx, and f_last are held stable.
- Handshake in cycle k means the next beat is presented in cycle k+1. There are no bubbles: with f_ready tied high, beats 0..127 occupy cycles 1..128.
- Last beat accepted in cycle k:
  - cycle k+1: f_valid = 0, done = 1, busy = 0;
  - cycle k+2: IDLE, and a new start is accepted there at the earliest.
- After the last handshake, f_idx wraps to 0 and must not emit beat 128.
- Reset mid-run returns all state to reset values. No partial done is produced.
- Inputs Pr, H, and seed may change freely after the start cycle.

## Structure
- Shared package zaap_pkg holds:
  - constants N and IDXW;
  - LFSR taps and the zero-seed substitute;
  - typedef hd_t (logic [IDXW-1:0]) and vec_t (logic [N-1:0]);
  - the FSM state enum.
- Sub-module mask_gen, combinational: hd_t h and 7-bit rotation in → vec_t mask out (thermometer then rotl). It is reusable by the verification model.

## Test plan
- **Single vector:** reset, seed = 1, Pr = 0, H[0] = 3, f_ready = 1, start.
  - Required: cycle 1 has f_idx = 0 and f_data = 128'hE (rotation 1).
  - Required: beat 1 uses lfsr = 16'h0002, giving rotation 2.
- **Full stream:** Pr = alternating 1010…, H[i] = i, f_ready = 1.
  - Required: 128 beats in cycles 1..128, popcount(f_data ^ Pr) = i for each beat, and f_last only at idx 127.
  - Required: done in cycle 129 and busy low in cycle 129.
- **Backpressure:** f_ready toggles randomly, with an 8-cycle stall on idx 5.
  - Required: f_data and f_idx stay stable while stalled, and no beat is lost or duplicated.
  - Required: the stream matches the f_ready = 1 run beat for beat.
- **Boundaries:**
  - H[i] = 0 gives f_data = Pr.
  - H[i] = 127 gives exactly 127 flipped bits.
  - seed = 0 behaves identically to seed = 1.
- **Start while busy:** a second start at cycle 50 is ignored, and the stream continues unchanged from idx 49.
- **Reset mid-run:** rst asserted at beat 60 clears all outputs to 0 in the same cycle. A new start afterwards begins again at idx 0.

Source files
------------

// File: rtl/zaap_pkg.sv
// zaap_pkg: shared widths, types, FSM states and LFSR step for the PUF key pipeline
package zaap_pkg;
    localparam int N = 128;
    localparam int IDXW = 7;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_ZERO_SUB = 16'h0001;
    typedef logic [IDXW-1:0] hd_t;
    typedef logic [N-1:0] vec_t;
    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;
    // Fibonacci step: taps b15^b13^b12^b10 fed into bit 0
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/mask_gen.sv
// mask_gen: thermometer of h ones rotated left by rot over N bits
module mask_gen
    import zaap_pkg::*;
(
    input  hd_t             h,
    input  logic [IDXW-1:0] rot,
    output vec_t            mask
);
    vec_t           therm;
    logic [2*N-1:0] dbl;
    assign therm = (vec_t'(1) << h) - vec_t'(1);
    // upper half of the doubled word shifted left is the rotation
    assign dbl = {therm, therm} << rot;
    assign mask = dbl[2*N-1:N];
endmodule

// File: rtl/helper_data_gen.sv
// helper_data_gen: streams helper vectors F[i] = Pr ^ rotl(therm(H[i]), lfsr[6:0])
module helper_data_gen
    import zaap_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N-1:0]    Pr,
    input  logic [IDXW-1:0] H [0:N-1],
    input  logic [15:0]     seed,
    input  logic            f_ready,
    output logic            f_valid,
    output logic [N-1:0]    f_data,
    output logic [IDXW-1:0] f_idx,
    output logic            f_last,
    output logic            busy,
    output logic            done
);
    state_t      state_q;
    vec_t        pr_q;
    hd_t         h_q [0:N-1];
    logic [15:0] lfsr_q;
    logic        f_valid_q, f_last_q, busy_q, done_q;
    vec_t        f_data_q;
    hd_t         f_idx_q;
    logic        accept;
    logic [15:0] seed_eff, lfsr_d;
    hd_t         idx_d, h_sel;
    vec_t        pr_sel, mask;
    assign accept   = f_valid_q & f_ready;
    assign seed_eff = (seed == 16'd0) ? LFSR_ZERO_SUB : seed;
    // one mask generator serves both the first beat (from inputs) and later beats (from captured state)
    assign lfsr_d = (state_q == IDLE) ? seed_eff : lfsr_step(lfsr_q);
    assign idx_d  = (state_q == IDLE) ? '0 : f_idx_q + hd_t'(1);
    assign h_sel  = (state_q == IDLE) ? H[0] : h_q[idx_d];
    assign pr_sel = (state_q == IDLE) ? Pr : pr_q;
    mask_gen u_mask (
        .h    (h_sel),
        .rot  (lfsr_d[6:0]),
        .mask (mask)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pr_q      <= '0;
            h_q       <= '{default: '0};
            lfsr_q    <= '0;
            f_valid_q <= 1'b0;
            f_data_q  <= '0;
            f_idx_q   <= '0;
            f_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q   <= GEN;
                    pr_q      <= Pr;
                    h_q       <= H;
                    lfsr_q    <= lfsr_d;
                    f_valid_q <= 1'b1;
                    f_data_q  <= pr_sel ^ mask;
                    f_idx_q   <= '0;
                    f_last_q  <= 1'b0;
                    busy_q    <= 1'b1;
                end
                GEN: if (accept) begin
                    if (f_last_q) begin
                        state_q   <= DONE;
                        f_valid_q <= 1'b0;
                        f_data_q  <= '0;
                        f_idx_q   <= '0;
                        f_last_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        lfsr_q   <= lfsr_d;
                        f_idx_q  <= idx_d;
                        f_data_q <= pr_sel ^ mask;
                        f_last_q <= (idx_d == hd_t'(N-1));
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign f_valid = f_valid_q;
    assign f_data  = f_data_q;
    assign f_idx   = f_idx_q;
    assign f_last  = f_last_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule
